// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern generator.
package led_pkg;

    typedef enum logic [1:0] {
        BLINK   = 2'b00,
        CHASE   = 2'b01,
        BOUNCE  = 2'b10,
        BREATHE = 2'b11
    } mode_e;

    // Tick period in clock cycles; shifting the divider down to zero floors at one cycle.
    function automatic int unsigned tick_period(input int unsigned div, input logic [1:0] speed);
        int unsigned p;
        p = div >> speed;
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Step-rate prescaler: one-cycle tick every tick_period(TICK_DIV, speed) enabled cycles.
module tick_prescaler
    import led_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last;

    assign last = CNT_W'(tick_period(TICK_DIV, speed) - 32'd1);

    // >= lets a speed-up past the current count wrap on the very next enabled cycle
    assign tick = nrst & en & ~clr & (count >= last);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink / chase / bounce / breathe, stepped by tick_prescaler.
//   mode    | meaning
//   BLINK   | all LEDs toggle each tick
//   CHASE   | one-hot rotates left each tick
//   BOUNCE  | one-hot sweeps up then down, ends lit for one tick
//   BREATHE | PWM duty ramps 0..2^PWM_W..0, one level per tick
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LED    = 8,
    parameter int TICK_DIV = 25_000_000,
    parameter int PWM_W    = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [N_LED-1:0] led,
    output logic             tick
);
    localparam logic [PWM_W:0]   DUTY_MAX = {1'b1, {PWM_W{1'b0}}};
    localparam logic [N_LED-1:0] POS_INIT = {{(N_LED-1){1'b0}}, 1'b1};

    mode_e            mode_in;
    mode_e            mode_q;
    logic             mode_chg;
    logic             blink_q, blink_d;
    logic [N_LED-1:0] pos_q, pos_d;
    logic             dir_up_q, dir_up_d;
    logic [PWM_W:0]   duty_q, duty_d;
    logic             duty_up_q, duty_up_d;
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_on;
    logic [N_LED-1:0] led_d;

    assign mode_in  = mode_e'(mode);
    assign mode_chg = (mode_in != mode_q);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .nrst (nrst),
        .en   (en),
        .clr  (mode_chg),
        .speed(speed),
        .tick (tick)
    );

    always_comb begin
        blink_d   = blink_q;
        pos_d     = pos_q;
        dir_up_d  = dir_up_q;
        duty_d    = duty_q;
        duty_up_d = duty_up_q;
        // a mode change discards any coincident step (tick is already gated by clr)
        if (mode_chg) begin
            blink_d   = 1'b0;
            pos_d     = POS_INIT;
            dir_up_d  = 1'b1;
            duty_d    = '0;
            duty_up_d = 1'b1;
        end else if (tick) begin
            case (mode_q)
                BLINK: blink_d = ~blink_q;
                CHASE: pos_d = {pos_q[N_LED-2:0], pos_q[N_LED-1]};
                BOUNCE: begin
                    if (dir_up_q) begin
                        pos_d = pos_q << 1;
                        if (pos_q[N_LED-2]) dir_up_d = 1'b0;
                    end else begin
                        pos_d = pos_q >> 1;
                        if (pos_q[1]) dir_up_d = 1'b1;
                    end
                end
                BREATHE: begin
                    if (duty_up_q) begin
                        duty_d = duty_q + 1'b1;
                        if (duty_q == DUTY_MAX - 1'b1) duty_up_d = 1'b0;
                    end else begin
                        duty_d = duty_q - 1'b1;
                        if (duty_q == {{PWM_W{1'b0}}, 1'b1}) duty_up_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pwm_on = ({1'b0, pwm_cnt} < duty_d);
        led_d  = '0;
        case (mode_in)
            BLINK:         led_d = {N_LED{blink_d}};
            CHASE, BOUNCE: led_d = pos_d;
            BREATHE:       led_d = {N_LED{pwm_on}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            mode_q    <= mode_in;
            blink_q   <= 1'b0;
            pos_q     <= POS_INIT;
            dir_up_q  <= 1'b1;
            duty_q    <= '0;
            duty_up_q <= 1'b1;
            pwm_cnt   <= '0;
            led       <= '0;
        end else begin
            mode_q    <= mode_in;
            blink_q   <= blink_d;
            pos_q     <= pos_d;
            dir_up_q  <= dir_up_d;
            duty_q    <= duty_d;
            duty_up_q <= duty_up_d;
            if (en) pwm_cnt <= pwm_cnt + 1'b1;
            if (en || mode_chg) led <= led_d;
        end
    end

endmodule
